// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Clamp a latency parameter into the counter's legal 1..15 range.
  function automatic logic [CNT_W-1:0] lat_cnt(input int lat);
    if (lat < 1) begin
      return CNT_W'(1);
    end
    if (lat > 15) begin
      return CNT_W'(15);
    end
    return lat[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin picker; the last-grant pointer is held by the parent.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_id_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |req_i;
    gnt_id_o = PORT_CPU;
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_i;
    end else if (req_i[PORT_DBG]) begin
      gnt_id_o = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between CPU load/store and debug reads.
// Optional halt gating of both ports is enabled with MEM_ARB_HALT_GATE_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset_all,
  input  logic          halt,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_e    fsm_state
);

  // Handshake: a requester holds req (with stable address/data) until its
  // one-cycle done pulse; gnt marks the single mem_en cycle of its access.

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 win_q;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;
  logic                 last_q;
  logic [DW-1:0]        cpu_rdata_q;
  logic [DW-1:0]        dbg_rdata_q;

  logic                 cpu_elig;
  logic                 dbg_elig;
  logic                 pick_id;
  logic                 pick_valid;
  logic                 grant_now;
  logic                 capture_now;

`ifdef MEM_ARB_HALT_GATE_EN
  assign cpu_elig  = cpu_req & ~halt;
  assign dbg_elig  = dbg_req & halt;
  assign cpu_stall = cpu_req & ~cpu_done & ~halt;
`else
  logic unused_halt;
  assign unused_halt = halt;
  assign cpu_elig    = cpu_req;
  assign dbg_elig    = dbg_req;
  assign cpu_stall   = cpu_req & ~cpu_done;
`endif

  rr_pick2 u_pick (
    .req_i    ({dbg_elig, cpu_elig}),
    .last_i   (last_q),
    .gnt_id_o (pick_id),
    .valid_o  (pick_valid)
  );

  assign grant_now   = (state_q == IDLE) && pick_valid;
  assign capture_now = (state_q == WAIT) && (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    if (capture_now) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en   = (state_q == ACCESS);
    mem_we   = (state_q == ACCESS) & we_q;
    cpu_gnt  = (state_q == ACCESS) & (win_q == PORT_CPU);
    dbg_gnt  = (state_q == ACCESS) & (win_q == PORT_DBG);
    cpu_done = (state_q == RESP) & (win_q == PORT_CPU);
    dbg_done = (state_q == RESP) & (win_q == PORT_DBG);
  end

  // Winner latch and round-robin pointer; debug accesses are always reads.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      win_q   <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= PORT_DBG;
    end else if (grant_now) begin
      win_q  <= pick_id;
      last_q <= pick_id;
      if (pick_id == PORT_CPU) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= dbg_addr;
        wdata_q <= '0;
      end
    end
  end

  // Counter reaches 1 in the cycle mem_rdata becomes valid.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      cnt_q <= lat_cnt(MEM_LAT);
    end else if ((state_q == WAIT) && !capture_now) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (capture_now) begin
      if (win_q == PORT_DBG) begin
        dbg_rdata_q <= mem_rdata;
      end else if (!we_q) begin
        cpu_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a memory stub and reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk;
  logic          reset_all;
  logic          halt;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic          dbg_done;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  arb_state_e    fsm_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L)) dut (
    .clk       (clk),
    .reset_all (reset_all),
    .halt      (halt),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_gnt   (dbg_gnt),
    .dbg_done  (dbg_done),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory stub ----------------
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [16];

  always @(posedge clk) begin
    pipe[0] <= mem_en ? mem[mem_addr] : (32'hBAD0_0000 | 32'(cyc));
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = pipe[L-1];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [0:0]    exp_q[$];
  int            en_stamps[$];
  int            en_cnt = 0;
  logic          prev_en = 1'b0;
  logic [DW-1:0] ref_mem [256];
  logic          exp_last;
  logic [DW-1:0] exp_cpu_rd;
  logic [DW-1:0] exp_dbg_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_all) begin
      if (cpu_gnt || dbg_gnt) begin
        check("gnt_onehot", 64'(cpu_gnt & dbg_gnt), 64'd0);
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", 64'({cpu_gnt, dbg_gnt}), 64'd0);
        end else begin
          check("gnt_order", 64'(dbg_gnt), 64'(exp_q.pop_front()));
        end
      end
      if (mem_en) begin
        en_cnt++;
        en_stamps.push_back(cyc);
        check("mem_en_b2b", 64'(prev_en), 64'd0);
      end
      prev_en = mem_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_last   = PORT_DBG;
    exp_cpu_rd = '0;
    exp_dbg_rd = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_all = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; dbg_addr = '0;
    model_reset();
    repeat (3) tick();
    check("rst_state", 64'(fsm_state), 64'(IDLE));
    check("rst_outs", 64'({cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_en, mem_we, cpu_stall}), 64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset_all = 1'b1;
    tick();
  endtask

  // One CPU and/or debug access started in the same cycle; the model orders them.
  task automatic run_pair(input bit uc, input bit cwe, input logic [AW-1:0] ca,
                          input logic [DW-1:0] cwd, input bit ud, input logic [AW-1:0] da);
    bit first, port;
    int exp_cg, exp_cd, exp_dg, exp_dd;
    int cg, cd, dg, dd, n;
    bit cp, dp;
    first = (uc && ud) ? ~exp_last : ud;
    exp_cg = -1; exp_cd = -1; exp_dg = -1; exp_dd = -1;
    for (int k = 0; k < 2; k++) begin
      port = (k == 0) ? first : ~first;
      if ((port == PORT_CPU && uc) || (port == PORT_DBG && ud)) begin
        if (port == PORT_CPU) begin
          exp_cg = (k == 0) ? 1 : L + 4;
          exp_cd = (k == 0) ? L + 2 : 2 * L + 5;
          if (cwe) ref_mem[ca] = cwd;
          else     exp_cpu_rd = ref_mem[ca];
        end else begin
          exp_dg = (k == 0) ? 1 : L + 4;
          exp_dd = (k == 0) ? L + 2 : 2 * L + 5;
          exp_dbg_rd = ref_mem[da];
        end
        exp_q.push_back(port);
        exp_last = port;
      end
    end
    cpu_req = uc; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dbg_req = ud; dbg_addr = da;
    cp = uc; dp = ud; n = 0;
    cg = -1; cd = -1; dg = -1; dd = -1;
    while ((cp || dp) && n < 60) begin
      tick();
      n++;
      if (cp) check("cpu_stall", 64'(cpu_stall), 64'(n != exp_cd));
      if (cpu_gnt) begin
        cg = n;
        check("cpu_mem_we", 64'(mem_we), 64'(cwe));
        check("cpu_mem_addr", 64'(mem_addr), 64'(ca));
        if (cwe) check("cpu_mem_wdata", 64'(mem_wdata), 64'(cwd));
      end
      if (dbg_gnt) begin
        dg = n;
        check("dbg_mem_we", 64'(mem_we), 64'd0);
        check("dbg_mem_addr", 64'(mem_addr), 64'(da));
      end
      if (cpu_done && cp) begin
        cd = n;
        check("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu_rd));
        cpu_req = 1'b0;
        cp = 1'b0;
      end
      if (dbg_done && dp) begin
        dd = n;
        check("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg_rd));
        dbg_req = 1'b0;
        dp = 1'b0;
      end
    end
    if (uc) begin
      check("cpu_gnt_cycle", 64'(cg), 64'(exp_cg));
      check("cpu_done_cycle", 64'(cd), 64'(exp_cd));
    end
    if (ud) begin
      check("dbg_gnt_cycle", 64'(dg), 64'(exp_dg));
      check("dbg_done_cycle", 64'(dd), 64'(exp_dd));
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int base, dones, n, en0;
    logic [AW-1:0] ca, da;
    halt = 1'b0;
    reset_all = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    do_reset();

    // store then load at 0x10
    run_pair(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00);
    run_pair(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h00);
    check("load_deadbeef", 64'(cpu_rdata), 64'hDEADBEEF);

    // simultaneous requests after reset: CPU first, then debug
    do_reset();
    en0 = en_cnt;
    run_pair(1'b1, 1'b0, 8'h20, 32'h0, 1'b1, 8'h10);
    check("both_en_count", 64'(en_cnt - en0), 64'd2);
    check("both_dbg_deadbeef", 64'(dbg_rdata), 64'hDEADBEEF);

    // both ports held for six accesses
    do_reset();
    ca = 8'h30; da = 8'h31;
    for (int i = 0; i < 6; i++) exp_q.push_back(i[0]);
    base = en_stamps.size();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    dbg_req = 1'b1; dbg_addr = da;
    dones = 0; n = 0;
    while (dones < 6 && n < 120) begin
      tick();
      n++;
      if (cpu_done) begin dones++; check("cont_cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[ca])); end
      if (dbg_done) begin dones++; check("cont_dbg_rdata", 64'(dbg_rdata), 64'(ref_mem[da])); end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    check("cont_done_count", 64'(dones), 64'd6);
    check("cont_en_count", 64'(en_stamps.size() - base), 64'd6);
    for (int i = 1; i < 6; i++) begin
      if (base + i < en_stamps.size())
        check("cont_spacing", 64'(en_stamps[base+i] - en_stamps[base+i-1]), 64'(L + 3));
    end
    exp_cpu_rd = ref_mem[ca];
    exp_dbg_rd = ref_mem[da];
    exp_last   = PORT_DBG;

    // reset asserted while waiting on memory
    exp_q.push_back(PORT_CPU);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h44;
    tick();
    tick();
    reset_all = 1'b0;
    #1;
    check("wrst_state", 64'(fsm_state), 64'(IDLE));
    check("wrst_outs", 64'({cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_en, mem_we}), 64'd0);
    check("wrst_rdata", 64'({cpu_rdata, dbg_rdata}), 64'd0);
    check("wrst_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    cpu_req = 1'b0;
    model_reset();
    en0 = en_cnt;
    repeat (2) tick();
    reset_all = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_done || dbg_done) dones++;
    end
    check("wrst_no_done", 64'(dones), 64'd0);
    check("wrst_no_en", 64'(en_cnt - en0), 64'd0);
    run_pair(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h00);

    // randomized traffic over a small address window
    for (int t = 0; t < 20; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      run_pair(mode != 1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
               mode != 0, AW'($urandom_range(0, 7)));
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory of the multi-cycle sort CPU between the CPU load/store path and the debug/inspection port (loc/sel-style readout).
- Sits between the datapath memory stage, the debug mux and the memory array.
- Sequences each access through a fixed-latency protocol and back-pressures the control path through a stall signal.

Parameters:
- AW, 8, memory address width (word address).
- DW, 32, data width.
- MEM_LAT, 2, memory read latency in cycles after the mem_en cycle; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_all  in  1  asynchronous, active-low reset.
- halt  in  1  CPU halted (HALT from top level).
- cpu_req  in  1  CPU access request; held until cpu_done.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  store data.
- cpu_gnt  out  1  one-cycle pulse; CPU request accepted.
- cpu_done  out  1  one-cycle pulse; access complete.
- cpu_rdata  out  DW  load data; valid with cpu_done, held until the next CPU done.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done.
- dbg_req  in  1  debug read request; held until dbg_done.
- dbg_addr  in  AW  debug address.
- dbg_gnt  out  1  one-cycle pulse; debug request accepted.
- dbg_done  out  1  one-cycle pulse; read data valid.
- dbg_rdata  out  DW  debug read data; held until the next debug done.
- mem_en  out  1  memory strobe; exactly one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (asynchronous, reset_all = 0):
  - State goes to IDLE.
  - All outputs go to 0, including rdata registers and mem_addr/mem_wdata.
  - The round-robin pointer points at DBG, so the CPU wins the first conflict.
  - An access interrupted by reset is abandoned with no done pulse, and no extra mem_en is issued.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE: if an eligible request exists, go to ACCESS. Latch the winner's id, addr, we and wdata. Debug is always a read.
  - ACCESS (1 cycle):
    - mem_en = 1; mem_we/addr/wdata come from the latch.
    - The winner's gnt = 1.
    - Load the counter with MEM_LAT and go to WAIT.
  - WAIT: decrement the counter. When it reaches 1, capture mem_rdata into the winner's rdata register (CPU stores leave cpu_rdata unchanged), then go to RESP.
  - RESP (1 cycle): the winner's done = 1. Go to IDLE. Requests are not sampled in RESP.
- Timing with the request first seen in IDLE at cycle 0:
  - gnt and mem_en at cycle 1.
  - done at cycle 2+MEM_LAT.
  - Minimum spacing between accesses: MEM_LAT+3 cycles.
- Arbitration happens in IDLE only.
  - Single requester: that requester wins.
  - Both requesting: the port not granted last wins. The pointer updates on every grant.
- Request dropped after gnt: the access still completes and done still pulses. A request dropped before gnt is ignored.
- mem_en is never high in two consecutive cycles; it is high exactly once per grant.
- cpu_stall stays high from the cycle cpu_req rises through the cycle before cpu_done.
- halt has no effect unless the optional feature is compiled in.

Optional Feature:
- Macro: MEM_ARB_HALT_GATE_EN.
- Defined:
  - dbg_req is eligible only while halt = 1.
  - cpu_req is eligible only while halt = 0.
  - An access already past IDLE always completes regardless of halt changes.
  - cpu_stall is forced to 0 while halt = 1.
- Undefined: halt is ignored and both ports arbitrate round-robin at all times.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, WAIT, RESP);
  - port id constants PORT_CPU = 0, PORT_DBG = 1;
  - counter width CNT_W = 4.
- One sub-module, rr_pick2: a 2-input round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: grant id, any-valid.
  - Purely combinational. The pointer register lives in the parent.

Test Plan:
- CPU store then load, MEM_LAT = 2:
  - Store 0xDEADBEEF to addr 0x10 → mem_en at cycle 1 with we = 1; cpu_done at cycle 4.
  - Load from 0x10 → cpu_rdata = 0xDEADBEEF at the next cpu_done.
- Simultaneous cpu_req and dbg_req after reset → CPU granted first, debug granted on the next access; both dbg_rdata and cpu_rdata correct; mem_en count = 2.
- Both ports holding requests continuously for 6 accesses → grants alternate CPU, DBG, CPU, …; spacing between mem_en pulses = 5 cycles.
- reset_all asserted during WAIT → outputs 0 immediately, no done pulse; the next request completes normally.
- MEM_LAT = 1 and MEM_LAT = 15 builds → done exactly 3 and 17 cycles after the request cycle.
- MEM_ARB_HALT_GATE_EN, halt = 0 with dbg_req held → no dbg_gnt.
  - Raise halt → dbg_gnt on the next IDLE cycle.
  - cpu_req while halted → no cpu_gnt, cpu_stall = 0.
